// File: rtl/seq_addsub_pkg.sv
// Shared definitions for the multi-cycle adder/subtractor: modes, FSM states
// and the saturation limit helper.
package seq_addsub_pkg;

  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_SUB = 2'b01;
  localparam logic [1:0] MODE_ADC = 2'b10;
  localparam logic [1:0] MODE_SBB = 2'b11;

  // Widest operand the saturation helper can describe.
  localparam int SAT_MAX_W = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Signed min (neg=1) or max (neg=0) for a width-bit word, zero-extended.
  function automatic logic [SAT_MAX_W-1:0] sat_limit(input int width, input logic neg);
    logic [SAT_MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < SAT_MAX_W; i++) begin
      if (i < width - 1)
        v[i] = ~neg;
      else if (i == width - 1)
        v[i] = neg;
    end
    return v;
  endfunction

endpackage

// File: rtl/seq_addsub_chunk.sv
// Combinational CHUNK-bit ripple adder; also exposes the carry into its MSB
// so the last chunk can produce the signed overflow flag.
module addsub_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar gi = 0; gi < CHUNK; gi++) begin : g_bit
    assign sum[gi]  = a[gi] ^ b[gi] ^ c[gi];
    assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
  end

  assign cout  = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/seq_addsub.sv
// Multi-cycle two's-complement add/sub: one shared CHUNK-bit adder walks the
// operands LSB-first, with valid/ready handshakes and optional saturation.
module seq_addsub
  import seq_addsub_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CHUNK    = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NCHUNK - 1);

  if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0 || WIDTH > SAT_MAX_W) begin : g_param_check
    $error("seq_addsub: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg, b_reg, result_reg;
  logic [CNT_W-1:0] idx_reg;
  logic             run_carry_reg;
  logic             in_ready_reg, out_valid_reg;
  logic             carry_reg, overflow_reg, zero_reg, negative_reg;

  logic [CHUNK-1:0]     a_chunk, b_chunk, sum;
  logic                 cout, c_msb, cin_next, ovf_next;
  logic [WIDTH-1:0]     raw_next, final_next;
  logic [SAT_MAX_W-1:0] sat_wide;

  assign a_chunk = a_reg[idx_reg*CHUNK +: CHUNK];
  assign b_chunk = b_reg[idx_reg*CHUNK +: CHUNK];

  addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a     (a_chunk),
    .b     (b_chunk),
    .cin   (run_carry_reg),
    .sum   (sum),
    .cout  (cout),
    .c_msb (c_msb)
  );

  always_comb begin
    cin_next = carry_in;
    case (mode)
      MODE_ADD: cin_next = 1'b0;
      MODE_SUB: cin_next = 1'b1;
      default:  cin_next = carry_in;
    endcase
  end

  // Only meaningful on the last chunk, where it becomes the committed result.
  always_comb begin
    raw_next = result_reg;
    raw_next[idx_reg*CHUNK +: CHUNK] = sum;
    ovf_next   = cout ^ c_msb;
    sat_wide   = sat_limit(WIDTH, a_reg[WIDTH-1]);
    final_next = (SATURATE && ovf_next) ? sat_wide[WIDTH-1:0] : raw_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      a_reg         <= '0;
      b_reg         <= '0;
      result_reg    <= '0;
      idx_reg       <= '0;
      run_carry_reg <= 1'b0;
      carry_reg     <= 1'b0;
      overflow_reg  <= 1'b0;
      zero_reg      <= 1'b0;
      negative_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid && in_ready_reg) begin
            a_reg         <= a;
            b_reg         <= b ^ {WIDTH{mode[0]}};
            run_carry_reg <= cin_next;
            idx_reg       <= '0;
            in_ready_reg  <= 1'b0;
            state_reg     <= RUN;
          end
        end
        RUN: begin
          if (idx_reg == LAST_IDX) begin
            result_reg    <= final_next;
            carry_reg     <= cout;
            overflow_reg  <= ovf_next;
            zero_reg      <= (final_next == '0);
            negative_reg  <= final_next[WIDTH-1];
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end else begin
            result_reg    <= raw_next;
            run_carry_reg <= cout;
            idx_reg       <= idx_reg + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg     <= IDLE;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign result    = result_reg;
  assign carry     = carry_reg;
  assign overflow  = overflow_reg;
  assign zero      = zero_reg;
  assign negative  = negative_reg;

endmodule

// File: tb/tb_seq_addsub.sv
// Self-checking bench: a plain and a saturating instance share one stimulus
// stream and are compared against an integer-arithmetic reference model.
module tb_seq_addsub;
  import seq_addsub_pkg::*;

  localparam int WIDTH  = 16;
  localparam int CHUNK  = 4;
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam longint MASK = (longint'(1) << WIDTH) - 1;
  localparam longint SMAX = (longint'(1) << (WIDTH - 1)) - 1;
  localparam longint SMIN = -(longint'(1) << (WIDTH - 1));

  logic             clk, rst_n, in_valid, out_ready, carry_in;
  logic [WIDTH-1:0] a, b;
  logic [1:0]       mode;
  logic             in_ready0, out_valid0, carry0, overflow0, zero0, negative0;
  logic             in_ready1, out_valid1, carry1, overflow1, zero1, negative1;
  logic [WIDTH-1:0] result0, result1;

  int n_checks = 0;
  int n_fails  = 0;

  seq_addsub #(.WIDTH(WIDTH), .CHUNK(CHUNK), .SATURATE(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a), .b(b), .mode(mode), .carry_in(carry_in),
    .out_valid(out_valid0), .out_ready(out_ready), .result(result0),
    .carry(carry0), .overflow(overflow0), .zero(zero0), .negative(negative0)
  );

  seq_addsub #(.WIDTH(WIDTH), .CHUNK(CHUNK), .SATURATE(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .mode(mode), .carry_in(carry_in),
    .out_valid(out_valid1), .out_ready(out_ready), .result(result1),
    .carry(carry1), .overflow(overflow1), .zero(zero1), .negative(negative1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact signed/unsigned arithmetic on wide integers.
  task automatic model(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                       input logic [1:0] m, input logic ci, input bit sat,
                       output logic [WIDTH-1:0] r, output logic c, output logic v,
                       output logic z, output logic n);
    longint ua, ub, sa, sb, cv, usum, ex;
    ua = longint'(ta);
    ub = longint'(tb_);
    sa = (ua > SMAX) ? ua - (MASK + 1) : ua;
    sb = (ub > SMAX) ? ub - (MASK + 1) : ub;
    cv = (m == MODE_ADD) ? 0 : (m == MODE_SUB) ? 1 : longint'(ci);
    if (m[0]) begin
      usum = ua + (MASK - ub) + cv;
      ex   = sa - sb - (1 - cv);
    end else begin
      usum = ua + ub + cv;
      ex   = sa + sb + cv;
    end
    c = (usum > MASK);
    v = (ex > SMAX) || (ex < SMIN);
    if (sat && v)
      r = (ex > SMAX) ? WIDTH'(SMAX) : WIDTH'(SMIN);
    else
      r = WIDTH'(usum & MASK);
    z = (r == '0);
    n = r[WIDTH-1];
  endtask

  task automatic do_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                       input logic [1:0] m, input logic ci, input int hold, input string tag);
    logic [WIDTH-1:0] er0, er1;
    logic ec0, ev0, ez0, en0, ec1, ev1, ez1, en1;
    model(ta, tb_, m, ci, 1'b0, er0, ec0, ev0, ez0, en0);
    model(ta, tb_, m, ci, 1'b1, er1, ec1, ev1, ez1, en1);
    check({tag, " idle_ready"}, 32'({in_ready1, in_ready0}), 32'h3);
    a = ta; b = tb_; mode = m; carry_in = ci; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); mode = 2'($urandom); carry_in = 1'($urandom);
    for (int k = 1; k <= NCHUNK; k++) begin
      @(posedge clk); #1;
      check({tag, " latency"}, 32'({out_valid1, out_valid0, in_ready1, in_ready0}),
            (k == NCHUNK) ? 32'hC : 32'h0);
    end
    check({tag, " result0"}, 32'(result0), 32'(er0));
    check({tag, " result1"}, 32'(result1), 32'(er1));
    check({tag, " flags0"}, 32'({carry0, overflow0, zero0, negative0}), 32'({ec0, ev0, ez0, en0}));
    check({tag, " flags1"}, 32'({carry1, overflow1, zero1, negative1}), 32'({ec1, ev1, ez1, en1}));
    for (int k = 0; k < hold; k++) begin
      if (k == hold / 2) in_valid = 1'b1;
      a = WIDTH'($urandom); b = WIDTH'($urandom);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check({tag, " hold_hs"}, 32'({out_valid1, out_valid0, in_ready1, in_ready0}), 32'hC);
      check({tag, " hold_result"}, {result1, result0}, {er1, er0});
      check({tag, " hold_flags"},
            32'({carry1, overflow1, zero1, negative1, carry0, overflow0, zero0, negative0}),
            32'({ec1, ev1, ez1, en1, ec0, ev0, ez0, en0}));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " release"}, 32'({out_valid1, out_valid0, in_ready1, in_ready0}), 32'h3);
    $display("op %-12s a=%h b=%h mode=%b cin=%b hold=%0d -> r0=%h r1=%h c=%b v=%b z=%b n=%b",
             tag, ta, tb_, m, ci, hold, result0, result1, carry0, overflow0, zero0, negative0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; mode = MODE_ADD; carry_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hs", 32'({in_ready1, in_ready0, out_valid1, out_valid0}), 32'hC);
    check("reset_result", {result1, result0}, 32'h0);
    check("reset_flags", 32'({carry1, overflow1, zero1, negative1, carry0, overflow0, zero0, negative0}), 32'h0);
    $display("reset in_ready=%b out_valid=%b result=%h", in_ready0, out_valid0, result0);
    rst_n = 1'b1;

    do_op(16'h0004, 16'h0002, MODE_ADD, 1'b0, 0, "add_small");
    do_op(16'h7FFF, 16'h0001, MODE_ADD, 1'b0, 0, "add_ovf");
    do_op(16'h0005, 16'h0007, MODE_SUB, 1'b0, 0, "sub_neg");
    do_op(16'h1234, 16'h1234, MODE_SUB, 1'b1, 0, "sub_zero");
    do_op(16'hFFFF, 16'h0001, MODE_ADD, 1'b0, 0, "mw_lo");
    do_op(16'h0000, 16'h0000, MODE_ADC, 1'b1, 0, "mw_hi");
    do_op(16'h0005, 16'h0003, MODE_SBB, 1'b0, 0, "sbb");
    do_op(16'h0005, 16'h0003, MODE_SBB, 1'b1, 0, "sbb_nb");
    do_op(16'h8000, 16'h0001, MODE_SUB, 1'b0, 0, "sub_ovf_min");
    do_op(16'h8000, 16'h8000, MODE_ADD, 1'b0, 0, "add_ovf_min");
    do_op(16'h1111, 16'h2222, MODE_ADC, 1'b1, 10, "backpressure");

    // Reset during the second RUN cycle must discard the operation.
    a = 16'h4321; b = 16'h1111; mode = MODE_ADD; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrun_reset_hs", 32'({in_ready1, in_ready0, out_valid1, out_valid0}), 32'hC);
    check("midrun_reset_result", {result1, result0}, 32'h0);
    for (int k = 0; k < NCHUNK + 2; k++) begin
      @(posedge clk); #1;
      check("no_stale_result", 32'({out_valid1, out_valid0}), 32'h0);
    end
    $display("midrun reset in_ready=%b out_valid=%b result=%h", in_ready0, out_valid0, result0);
    do_op(16'h4321, 16'h1111, MODE_SUB, 1'b0, 0, "after_reset");

    for (int i = 0; i < 40; i++)
      do_op(WIDTH'($urandom), WIDTH'($urandom), 2'($urandom), 1'($urandom),
            int'($urandom_range(0, 2)), "random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
